// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - bus controller state encodings and default ULX3S memory map
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TMO,
        ST_ACK,
        ST_VPA,
        ST_ERR
    } bus_state_t;

    // ch0 ROM, ch1 RAM, ch2..ch4 6800-style peripherals (ACIA, GPIO)
    localparam logic [19:0] DEF_CS_MAP   = 20'h43210;
    localparam logic [19:0] DEF_WAIT_MAP = 20'h00001;
    localparam logic [4:0]  DEF_VPA_MASK = 5'b11100;

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// rtl/m68k_bus_ctrl_if.sv - CPU-side bus signals; BUSCTRL_ERRLOG_EN adds error-log signals
interface m68k_bus_ctrl_if #(
    parameter int ADDR_W = 24,
    parameter int NUM_CS = 5
);
    logic [ADDR_W-1:1] addr;
    logic              as_n;
    logic              rw;
    logic [NUM_CS-1:0] cs;
    logic              dtack_n;
    logic              vpa_n;
    logic              berr_n;
`ifdef BUSCTRL_ERRLOG_EN
    logic [ADDR_W-1:1] err_addr;
    logic              err_rw;
    logic              err_valid;
    logic              err_clr;

    modport master (output addr, as_n, rw, err_clr,
                    input  cs, dtack_n, vpa_n, berr_n, err_addr, err_rw, err_valid);
    modport slave  (input  addr, as_n, rw, err_clr,
                    output cs, dtack_n, vpa_n, berr_n, err_addr, err_rw, err_valid);
`else
    modport master (output addr, as_n, rw,
                    input  cs, dtack_n, vpa_n, berr_n);
    modport slave  (input  addr, as_n, rw,
                    output cs, dtack_n, vpa_n, berr_n);
`endif
endinterface

// File: rtl/m68k_addr_decode.sv
// rtl/m68k_addr_decode.sv - combinational priority decoder; lowest matching channel wins
module m68k_addr_decode #(
    parameter int                        DEC_W    = 4,
    parameter int                        NUM_CS   = 5,
    parameter int                        WAIT_W   = 4,
    parameter logic [NUM_CS*DEC_W-1:0]   CS_MAP   = 20'h43210,
    parameter logic [NUM_CS*WAIT_W-1:0]  WAIT_MAP = 20'h00001,
    parameter logic [NUM_CS-1:0]         VPA_MASK = 5'b11100
) (
    input  logic [DEC_W-1:0]  field,
    input  logic              as_n,
    output logic [NUM_CS-1:0] cs,
    output logic              hit,
    output logic [WAIT_W-1:0] wait_val,
    output logic              vpa
);
    logic [NUM_CS-1:0] onehot;

    // Scan from the top down so the lowest matching index is applied last
    always_comb begin
        onehot   = '0;
        hit      = 1'b0;
        wait_val = '0;
        vpa      = 1'b0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (field == CS_MAP[i*DEC_W +: DEC_W]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                hit       = 1'b1;
                wait_val  = WAIT_MAP[i*WAIT_W +: WAIT_W];
                vpa       = VPA_MASK[i];
            end
        end
    end

    assign cs = onehot & {NUM_CS{~as_n}};

endmodule

// File: rtl/m68k_bus_ctrl.sv
// rtl/m68k_bus_ctrl.sv - 68000 bus cycle controller: chip selects, DTACKn/VPAn/BERRn
// Optional error capture enabled by defining BUSCTRL_ERRLOG_EN.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int                        ADDR_W   = 24,
    parameter int                        DEC_HI   = 15,
    parameter int                        DEC_LO   = 12,
    parameter int                        NUM_CS   = 5,
    parameter int                        WAIT_W   = 4,
    parameter logic [NUM_CS*(DEC_HI-DEC_LO+1)-1:0] CS_MAP = DEF_CS_MAP,
    parameter logic [NUM_CS*WAIT_W-1:0]  WAIT_MAP = DEF_WAIT_MAP,
    parameter logic [NUM_CS-1:0]         VPA_MASK = DEF_VPA_MASK,
    parameter int                        TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            rst,
    m68k_bus_ctrl_if.slave  bus
);
    localparam int DEC_W = DEC_HI - DEC_LO + 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int CNT_W = (TMO_W > WAIT_W) ? TMO_W : WAIT_W;

    bus_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dtack_n_q, vpa_n_q, berr_n_q;

    logic              hit;
    logic              vpa_ch;
    logic [WAIT_W-1:0] wait_val;

    m68k_addr_decode #(
        .DEC_W    (DEC_W),
        .NUM_CS   (NUM_CS),
        .WAIT_W   (WAIT_W),
        .CS_MAP   (CS_MAP),
        .WAIT_MAP (WAIT_MAP),
        .VPA_MASK (VPA_MASK)
    ) u_decode (
        .field    (bus.addr[DEC_HI:DEC_LO]),
        .as_n     (bus.as_n),
        .cs       (bus.cs),
        .hit      (hit),
        .wait_val (wait_val),
        .vpa      (vpa_ch)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.as_n) begin
                    if (hit && vpa_ch) begin
                        state_d = ST_VPA;
                    end else if (hit && wait_val == '0) begin
                        state_d = ST_ACK;
                    end else if (hit) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(wait_val) - CNT_W'(1);
                    end else begin
                        state_d = ST_TMO;
                        cnt_d   = CNT_W'(TIMEOUT - 2);
                    end
                end
            end
            ST_WAIT, ST_TMO: begin
                if (bus.as_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = (state_q == ST_WAIT) ? ST_ACK : ST_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK, ST_VPA, ST_ERR: begin
                if (bus.as_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are a registered decode of the next state, so they move on the same edge as it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dtack_n_q <= 1'b1;
            vpa_n_q   <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dtack_n_q <= (state_d != ST_ACK);
            vpa_n_q   <= (state_d != ST_VPA);
            berr_n_q  <= (state_d != ST_ERR);
        end
    end

    assign bus.dtack_n = dtack_n_q;
    assign bus.vpa_n   = vpa_n_q;
    assign bus.berr_n  = berr_n_q;

`ifdef BUSCTRL_ERRLOG_EN
    logic [ADDR_W-1:1] err_addr_q;
    logic              err_rw_q;
    logic              err_valid_q;
    logic              err_event;

    assign err_event = (state_q == ST_TMO) && (state_d == ST_ERR);

    // A fresh error beats a simultaneous clear; otherwise the first error is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_q  <= '0;
            err_rw_q    <= 1'b0;
            err_valid_q <= 1'b0;
        end else if (err_event && (!err_valid_q || bus.err_clr)) begin
            err_addr_q  <= bus.addr;
            err_rw_q    <= bus.rw;
            err_valid_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_valid_q <= 1'b0;
        end
    end

    assign bus.err_addr  = err_addr_q;
    assign bus.err_rw    = err_rw_q;
    assign bus.err_valid = err_valid_q;
`else
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.rw, bus.addr};
`endif

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// tb/tb_m68k_bus_ctrl.sv - randomized self-checking bench for m68k_bus_ctrl
module tb_m68k_bus_ctrl;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int codes [5] = '{0, 1, 2, 3, 4};
    int waits [5] = '{1, 0, 0, 0, 0};
    bit is_vpa[5] = '{0, 0, 1, 1, 1};

    logic        m_valid = 1'b0;
    logic [23:1] m_addr  = '0;
    logic        m_rw    = 1'b0;

    always #5 clk = ~clk;

    m68k_bus_ctrl_if #(.ADDR_W(24), .NUM_CS(5)) bus ();

    m68k_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // kind: 0 = DTACK, 1 = VPA, 2 = BERR; term = sampling edge (1-based) the strobe falls
    function automatic void classify(input logic [23:0] a, output int ch,
                                     output int kind, output int term);
        int f;
        f  = int'(a[15:12]);
        ch = -1;
        for (int i = 0; i < 5; i++)
            if (ch < 0 && codes[i] == f) ch = i;
        if (ch < 0)          begin kind = 2; term = TIMEOUT; end
        else if (is_vpa[ch]) begin kind = 1; term = 1; end
        else                 begin kind = 0; term = waits[ch] + 1; end
    endfunction

    task automatic check_err(input string tag);
`ifdef BUSCTRL_ERRLOG_EN
        total++;
        if (bus.err_valid !== m_valid) begin
            bad++;
            $display("FAIL %s err_valid got=%0b exp=%0b", tag, bus.err_valid, m_valid);
        end
        if (m_valid) begin
            total++;
            if (bus.err_addr !== m_addr || bus.err_rw !== m_rw) begin
                bad++;
                $display("FAIL %s err_addr/rw got=%h/%0b exp=%h/%0b",
                         tag, bus.err_addr, bus.err_rw, m_addr, m_rw);
            end
        end
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Called and returns at a negedge; as_n is sampled low on edges 1..hold
    task automatic run_txn(input string tag, input logic [23:0] a, input int hold,
                           input logic rw_v, input bit clr_at_term);
        int ch, kind, term;
        logic [4:0] exp_cs;
        bit low;
        classify(a, ch, kind, term);
        exp_cs = (ch >= 0) ? 5'(1 << ch) : 5'b0;
        bus.addr = a[23:1];
        bus.rw   = rw_v;
        bus.as_n = 1'b0;
`ifdef BUSCTRL_ERRLOG_EN
        if (clr_at_term && term == 1) bus.err_clr = 1'b1;
`endif
        #1;
        total++;
        if (bus.cs !== exp_cs) begin
            bad++;
            $display("FAIL %s cs got=%b exp=%b", tag, bus.cs, exp_cs);
        end
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (kind == 2 && k == term && (!m_valid || clr_at_term)) begin
                m_valid = 1'b1;
                m_addr  = a[23:1];
                m_rw    = rw_v;
            end
`ifdef BUSCTRL_ERRLOG_EN
            bus.err_clr = clr_at_term && (k + 1 == term);
`endif
            low = (k >= term);
            total++;
            if (bus.dtack_n !== !(low && kind == 0) || bus.vpa_n !== !(low && kind == 1) ||
                bus.berr_n !== !(low && kind == 2) || bus.cs !== exp_cs) begin
                bad++;
                $display("FAIL %s edge %0d dtack/vpa/berr/cs got=%b%b%b/%b exp=%b%b%b/%b",
                         tag, k, bus.dtack_n, bus.vpa_n, bus.berr_n, bus.cs,
                         !(low && kind == 0), !(low && kind == 1), !(low && kind == 2), exp_cs);
            end
        end
        bus.as_n = 1'b1;
        #1;
        total++;
        if (bus.cs !== 5'b0) begin
            bad++;
            $display("FAIL %s cs after release got=%b exp=00000", tag, bus.cs);
        end
        @(negedge clk);
        total++;
        if ({bus.dtack_n, bus.vpa_n, bus.berr_n} !== 3'b111) begin
            bad++;
            $display("FAIL %s release strobes got=%b%b%b exp=111", tag,
                     bus.dtack_n, bus.vpa_n, bus.berr_n);
        end
        check_err(tag);
    endtask

    task automatic test_reset();
        bus.as_n = 1'b1;
        bus.rw   = 1'b1;
        bus.addr = '0;
`ifdef BUSCTRL_ERRLOG_EN
        bus.err_clr = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.dtack_n, bus.vpa_n, bus.berr_n} !== 3'b111 || bus.cs !== 5'b0) begin
            bad++;
            $display("FAIL reset strobes/cs got=%b%b%b/%b exp=111/00000",
                     bus.dtack_n, bus.vpa_n, bus.berr_n, bus.cs);
        end
        check_err("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn("wait1_read",  24'h000100, 5,  1'b1, 1'b0);
        run_txn("wait0_write", 24'h001004, 3,  1'b0, 1'b0);
        run_txn("vpa_hold",    24'h003002, 20, 1'b1, 1'b0);
        run_txn("timeout",     24'h009000, TIMEOUT + 2, 1'b1, 1'b0);
    endtask

    task automatic test_err_clear();
`ifdef BUSCTRL_ERRLOG_EN
        run_txn("sticky_err", 24'h00A006, TIMEOUT + 1, 1'b0, 1'b0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_valid = 1'b0;
        check_err("err_clr");
        run_txn("err_new", 24'h00B002, TIMEOUT + 1, 1'b0, 1'b0);
        run_txn("clr_and_err", 24'h00C004, TIMEOUT + 1, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_abort();
        run_txn("abort_wait", 24'h000200, 1,  1'b1, 1'b0);
        run_txn("abort_tmo",  24'h00F000, 10, 1'b1, 1'b0);
        run_txn("after_abort", 24'h000400, 3, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [23:0] a;
        int hold, f;
        for (int n = 0; n < 30; n++) begin
            f    = $urandom_range(0, 7);
            a    = {8'($urandom), 4'(f), 11'($urandom), 1'b0};
            hold = (f >= 5 && $urandom_range(0, 1) == 1) ? $urandom_range(TIMEOUT, TIMEOUT + 3)
                                                         : $urandom_range(1, 6);
            run_txn("random", a, hold, 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_async_reset();
        bus.addr = 24'h001004 >> 1;
        bus.as_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.dtack_n !== 1'b0) begin
            bad++;
            $display("FAIL rst_ack pre dtack_n got=%b exp=0", bus.dtack_n);
        end
        #2 rst = 1'b1;
        bus.as_n = 1'b1;
        #1;
        total++;
        if ({bus.dtack_n, bus.vpa_n, bus.berr_n} !== 3'b111) begin
            bad++;
            $display("FAIL rst_ack strobes got=%b%b%b exp=111", bus.dtack_n, bus.vpa_n, bus.berr_n);
        end
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        run_txn("after_rst_ack", 24'h001008, 2, 1'b1, 1'b0);

        bus.addr = 24'h009000 >> 1;
        bus.as_n = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        bus.as_n = 1'b1;
        #1;
        total++;
        if ({bus.dtack_n, bus.vpa_n, bus.berr_n} !== 3'b111) begin
            bad++;
            $display("FAIL rst_tmo strobes got=%b%b%b exp=111", bus.dtack_n, bus.vpa_n, bus.berr_n);
        end
        @(negedge clk);
        rst = 1'b0;
        run_txn("after_rst_tmo", 24'h000100, 3, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err_clear();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
